pb_stopwatch_ctrl: RTL and testbench

Consumer of the debounced push-button level: converts `pb_debounced` into a single-cycle press pulse, classifies each press as short or long, and runs a two-digit BCD seconds counter (00–59) from those commands.
- Short press toggles run/pause.
- Long press clears the count and stops it.
- Sits directly downstream of the debounce stage, in the same clock domain, and drives the seven-segment display path.

---
 rtl/pb_stopwatch_ctrl.sv | 125 ++++++++++++
 tb/tb_pb_stopwatch_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_stopwatch_ctrl.sv
// ============================================================================
//  Module      : pb_stopwatch_ctrl
//  Description : Push-button stopwatch controller. Turns the debounced button
//                level into a press pulse, classifies presses as short or
//                long, and runs a two-digit BCD seconds counter (00-59).
//                Short press toggles run/pause; long press clears and stops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_stopwatch_ctrl #(
    parameter int LONG_CYCLES = 200,
    parameter int HOLD_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_debounced,
    input  logic       tick_en,
    output logic       one_pulse,
    output logic       long_press,
    output logic       running,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] C_LONG    = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] C_LONG_M1 = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] C_ONE     = HOLD_W'(1);

    state_t            r_state;
    logic              r_pb_q;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_done;
    logic              r_one_pulse;
    logic              r_long_press;
    logic [3:0]        r_sec_tens;
    logic [3:0]        r_sec_ones;

    logic              w_rise;
    logic              w_fall;
    logic              w_long_evt;
    logic              w_short;
    logic              w_advance;

    assign w_rise     = pb_debounced & ~r_pb_q;
    assign w_fall     = ~pb_debounced & r_pb_q;
    // The hold counter only passes LONG-1 -> LONG once per press, because it
    // saturates, so this fires a single time however long the button is held.
    assign w_long_evt = pb_debounced & (r_hold_cnt == C_LONG_M1);
    // A release that ends a long press must not also count as a short press.
    assign w_short    = w_fall & ~r_long_done;
    // The state before this edge decides whether a tick counts.
    assign w_advance  = (r_state == ST_RUN) & tick_en;

    // Button edge tracking, saturating hold counter and long-press latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pb_q      <= 1'b0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
        end else begin
            r_pb_q <= pb_debounced;
            if (!pb_debounced) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != C_LONG) begin
                r_hold_cnt <= r_hold_cnt + C_ONE;
            end
            if (w_long_evt) begin
                r_long_done <= 1'b1;
            end else if (w_fall) begin
                r_long_done <= 1'b0;
            end
        end
    end

    // Run/stop FSM, BCD seconds counter and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_STOP;
            r_one_pulse  <= 1'b0;
            r_long_press <= 1'b0;
            r_sec_tens   <= 4'd0;
            r_sec_ones   <= 4'd0;
        end else begin
            r_one_pulse  <= w_rise;
            r_long_press <= w_long_evt;
            if (w_long_evt) begin
                // Long press wins over any toggle or tick on the same edge
                r_state    <= ST_STOP;
                r_sec_tens <= 4'd0;
                r_sec_ones <= 4'd0;
            end else begin
                if (w_advance) begin
                    if (r_sec_ones == 4'd9) begin
                        r_sec_ones <= 4'd0;
                        if (r_sec_tens == 4'd5) begin
                            r_sec_tens <= 4'd0;
                        end else begin
                            r_sec_tens <= r_sec_tens + 4'd1;
                        end
                    end else begin
                        r_sec_ones <= r_sec_ones + 4'd1;
                    end
                end
                if (w_short) begin
                    r_state <= (r_state == ST_RUN) ? ST_STOP : ST_RUN;
                end
            end
        end
    end

    assign one_pulse  = r_one_pulse;
    assign long_press = r_long_press;
    assign running    = (r_state == ST_RUN);
    assign sec_tens   = r_sec_tens;
    assign sec_ones   = r_sec_ones;

endmodule

`default_nettype wire

// File: tb/tb_pb_stopwatch_ctrl.sv
// ============================================================================
//  Module      : tb_pb_stopwatch_ctrl
//  Description : Self-checking bench for pb_stopwatch_ctrl with a behavioural
//                seconds-count model, directed scenarios and random presses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_stopwatch_ctrl;

    localparam int LC = 4;

    logic       clk;
    logic       rst_n;
    logic       pb_debounced;
    logic       tick_en;
    logic       one_pulse;
    logic       long_press;
    logic       running;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    int errs;
    int checks;
    bit chk_en;

    // Behavioural model: count kept as a plain integer of seconds
    bit m_prev;
    int m_hold;
    bit m_ldone;
    bit m_run;
    int m_count;
    bit m_pulse;
    bit m_long;

    pb_stopwatch_ctrl #(
        .LONG_CYCLES (LC),
        .HOLD_W      (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb_debounced (pb_debounced),
        .tick_en      (tick_en),
        .one_pulse    (one_pulse),
        .long_press   (long_press),
        .running      (running),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = 1'b0;
        m_hold  = 0;
        m_ldone = 1'b0;
        m_run   = 1'b0;
        m_count = 0;
        m_pulse = 1'b0;
        m_long  = 1'b0;
    endtask

    task automatic model_step(input bit p, input bit t);
        bit rise;
        bit fall;
        bit lnow;
        int nh;
        rise = p && !m_prev;
        fall = !p && m_prev;
        nh   = p ? ((m_hold + 1 > LC) ? LC : m_hold + 1) : 0;
        lnow = (nh == LC) && (m_hold != LC);
        m_pulse = rise;
        m_long  = lnow;
        if (lnow) begin
            m_count = 0;
            m_run   = 1'b0;
        end else begin
            if (m_run && t) m_count = (m_count + 1) % 60;
            if (fall && !m_ldone) m_run = !m_run;
        end
        if (lnow) m_ldone = 1'b1;
        else if (fall) m_ldone = 1'b0;
        m_hold = nh;
        m_prev = p;
    endtask

    // Every cycle: compare all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("one_pulse", int'(one_pulse), int'(m_pulse));
            check("long_press", int'(long_press), int'(m_long));
            check("running", int'(running), int'(m_run));
            check("sec_tens", int'(sec_tens), m_count / 10);
            check("sec_ones", int'(sec_ones), m_count % 10);
        end
    end

    // One clock cycle with the given inputs; returns at the following negedge
    task automatic cyc(input bit p, input bit t);
        pb_debounced = p;
        tick_en      = t;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(p, t);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit p);
        #1;
        rst_n = 1'b0;
        model_reset();
        cyc(p, 1'b0);
        cyc(p, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic short_press();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic lit_digits(input string name, input int t, input int o);
        check({name, "_tens"}, int'(sec_tens), t);
        check({name, "_ones"}, int'(sec_ones), o);
    endtask

    initial begin
        int remain;
        bit lvl;
        errs         = 0;
        checks       = 0;
        chk_en       = 1'b0;
        rst_n        = 1'b0;
        pb_debounced = 1'b0;
        tick_en      = 1'b0;
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;

        // Reset with button held high, then onset pulse on the first edge
        do_reset(1'b1);
        check("rst_running", int'(running), 0);
        check("rst_one_pulse", int'(one_pulse), 0);
        cyc(1'b1, 1'b0);
        check("post_rst_pulse", int'(one_pulse), 1);
        cyc(1'b1, 1'b0);
        check("post_rst_pulse_end", int'(one_pulse), 0);

        // Short press starts, 5 ticks, second press stops, ticks ignored
        do_reset(1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("start_running", int'(running), 1);
        ticks(5);
        lit_digits("five_ticks", 0, 5);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("stop_running", int'(running), 0);
        ticks(3);
        lit_digits("frozen", 0, 5);

        // 58 -> 59 -> 00 -> 01
        do_reset(1'b0);
        short_press();
        ticks(58);
        lit_digits("at58", 5, 8);
        ticks(1);
        lit_digits("at59", 5, 9);
        ticks(1);
        lit_digits("wrap00", 0, 0);
        ticks(1);
        lit_digits("at01", 0, 1);

        // Long hold of 10 samples at 2/3
        do_reset(1'b0);
        short_press();
        ticks(23);
        lit_digits("at23", 2, 3);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 4) begin
                check("long_pulse", int'(long_press), 1);
                check("long_running", int'(running), 0);
                lit_digits("long_clear", 0, 0);
            end
            if (i > 4) check("no_second_long", int'(long_press), 0);
        end
        cyc(1'b0, 1'b0);
        check("long_release_no_toggle", int'(running), 0);

        // Exactly LC-1 samples is short, exactly LC samples is long
        for (int i = 0; i < LC - 1; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("three_is_short", int'(running), 1);
        for (int i = 1; i <= LC; i++) begin
            cyc(1'b1, 1'b0);
            if (i == LC) check("four_is_long", int'(long_press), 1);
        end
        cyc(1'b0, 1'b0);
        check("four_release", int'(running), 0);

        // Tick on the long-press edge is dropped
        short_press();
        ticks(3);
        for (int i = 0; i < LC - 1; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        lit_digits("tick_on_long", 0, 0);
        cyc(1'b0, 1'b0);

        // Tick on RUN->STOP release applies; on STOP->RUN it does not
        do_reset(1'b0);
        short_press();
        ticks(14);
        lit_digits("at14", 1, 4);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        lit_digits("tick_on_stop", 1, 5);
        check("tick_on_stop_run", int'(running), 0);
        ticks(3);
        lit_digits("frozen15", 1, 5);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check("tick_on_start_run", int'(running), 1);
        lit_digits("tick_on_start", 1, 5);

        // Asynchronous reset mid-count
        do_reset(1'b0);
        short_press();
        ticks(37);
        lit_digits("at37", 3, 7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_running", int'(running), 0);
        lit_digits("async", 0, 0);
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;

        // Random presses and ticks against the model
        lvl    = 1'b0;
        remain = 0;
        for (int n = 0; n < 4000; n++) begin
            if (remain == 0) begin
                lvl    = !lvl;
                remain = lvl ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 4));
            end
            remain--;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(lvl);
            end else begin
                cyc(lvl, $urandom_range(0, 2) == 0);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
